// File: rtl/phase_3_post_adder.sv
// DSP48A1 back end: optional M / carry-in registers, X/Z operand muxes, 48-bit add/sub
// with carry, and the P register that doubles as accumulator and cascade output.
module phase_3_post_adder #(
  parameter int MREG        = 1,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cem,
  input  logic        cecarryin,
  input  logic        cep,
  input  logic [7:0]  opmode,
  input  logic [35:0] mult_out,
  input  logic [47:0] conc_out,
  input  logic [47:0] c_in,
  input  logic [47:0] pcin,
  input  logic        carryin,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  localparam bit USE_CARRYIN_PORT = (CARRYINSEL == "CARRYIN");

  logic [35:0] r_m;
  logic        r_cin;
  logic [47:0] r_p;
  logic        r_co;

  logic        w_cin_sel;
  logic [35:0] w_m;
  logic        w_cin;
  logic [47:0] w_p_fb;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic [48:0] w_sum;
  logic        w_unused_opmode;

  assign w_unused_opmode = ^{opmode[6], opmode[4]};

  assign w_cin_sel = USE_CARRYIN_PORT ? carryin : opmode[5];
  assign w_m       = (MREG != 0)       ? r_m   : mult_out;
  assign w_cin     = (CARRYINREG != 0) ? r_cin : w_cin_sel;
  // Without a P register the feedback operand is tied off to avoid a combinational loop.
  assign w_p_fb    = (PREG != 0)       ? r_p   : 48'd0;

  always_comb begin
    w_x = 48'd0;
    case (opmode[1:0])
      2'd0:    w_x = 48'd0;
      2'd1:    w_x = {12'd0, w_m};
      2'd2:    w_x = w_p_fb;
      default: w_x = conc_out;
    endcase
  end

  always_comb begin
    w_z = 48'd0;
    case (opmode[3:2])
      2'd0:    w_z = 48'd0;
      2'd1:    w_z = pcin;
      2'd2:    w_z = w_p_fb;
      default: w_z = c_in;
    endcase
  end

  // Bit 48 is the carry on add and the borrow on subtract.
  always_comb begin
    if (opmode[7])
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + {48'd0, w_cin});
    else
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {48'd0, w_cin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_m <= 36'd0;
    else if (cem) r_m <= mult_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cin <= 1'b0;
    else if (cecarryin) r_cin <= w_cin_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p  <= 48'd0;
      r_co <= 1'b0;
    end else if (cep) begin
      r_p  <= w_sum[47:0];
      r_co <= w_sum[48];
    end
  end

  assign M         = w_m;
  assign P         = (PREG != 0)        ? r_p  : w_sum[47:0];
  assign CARRYOUT  = (CARRYOUTREG != 0) ? r_co : w_sum[48];
  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_phase_3_post_adder.sv
// Randomised and directed checks of phase_3_post_adder in three register configurations
// against an arithmetic reference model.
module tb_phase_3_post_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cem, cecarryin, cep;
  logic [7:0]  opmode;
  logic [35:0] mult_out;
  logic [47:0] conc_out, c_in, pcin;
  logic        carryin;

  logic [35:0] m_a, m_b, m_c;
  logic [47:0] p_a, p_b, p_c, pc_a, pc_b, pc_c;
  logic        co_a, co_b, co_c, cof_a, cof_b, cof_c;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;

  // Instance 0: all registered, carry-in from opmode[5].
  // Instance 1: MREG=0, PREG=1, others combinational, carry-in from port.
  // Instance 2: fully combinational, carry-in from port.
  localparam bit [2:0] K_MREG  = 3'b001;
  localparam bit [2:0] K_CREG  = 3'b001;
  localparam bit [2:0] K_PREG  = 3'b011;
  localparam bit [2:0] K_COREG = 3'b001;
  localparam bit [2:0] K_SELC  = 3'b110;

  logic [35:0] mdl_m   [3];
  logic        mdl_cin [3];
  logic [47:0] mdl_p   [3];
  logic        mdl_co  [3];

  always #5 clk = ~clk;

  phase_3_post_adder u_dut_a (
    .clk(clk), .rst_n(rst_n), .cem(cem), .cecarryin(cecarryin), .cep(cep),
    .opmode(opmode), .mult_out(mult_out), .conc_out(conc_out), .c_in(c_in),
    .pcin(pcin), .carryin(carryin),
    .M(m_a), .P(p_a), .PCOUT(pc_a), .CARRYOUT(co_a), .CARRYOUTF(cof_a)
  );

  phase_3_post_adder #(
    .MREG(0), .CARRYINREG(0), .PREG(1), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN")
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cem(cem), .cecarryin(cecarryin), .cep(cep),
    .opmode(opmode), .mult_out(mult_out), .conc_out(conc_out), .c_in(c_in),
    .pcin(pcin), .carryin(carryin),
    .M(m_b), .P(p_b), .PCOUT(pc_b), .CARRYOUT(co_b), .CARRYOUTF(cof_b)
  );

  phase_3_post_adder #(
    .MREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN")
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .cem(cem), .cecarryin(cecarryin), .cep(cep),
    .opmode(opmode), .mult_out(mult_out), .conc_out(conc_out), .c_in(c_in),
    .pcin(pcin), .carryin(carryin),
    .M(m_c), .P(p_c), .PCOUT(pc_c), .CARRYOUT(co_c), .CARRYOUTF(cof_c)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [48:0] ref_sum(input int k);
    logic [35:0] em;
    logic        csel, ecin;
    logic [47:0] pfb, x, z;
    em   = K_MREG[k] ? mdl_m[k] : mult_out;
    csel = K_SELC[k] ? carryin : opmode[5];
    ecin = K_CREG[k] ? mdl_cin[k] : csel;
    pfb  = K_PREG[k] ? mdl_p[k] : 48'd0;
    case (opmode[1:0])
      2'd0:    x = 48'd0;
      2'd1:    x = {12'd0, em};
      2'd2:    x = pfb;
      default: x = conc_out;
    endcase
    case (opmode[3:2])
      2'd0:    z = 48'd0;
      2'd1:    z = pcin;
      2'd2:    z = pfb;
      default: z = c_in;
    endcase
    if (opmode[7]) return {1'b0, z} - {1'b0, x} - {48'd0, ecin};
    else           return {1'b0, z} + {1'b0, x} + {48'd0, ecin};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mdl_m[k] = '0; mdl_cin[k] = 1'b0; mdl_p[k] = '0; mdl_co[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [48:0] s;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        s = ref_sum(k);
        if (cep) begin mdl_p[k] = s[47:0]; mdl_co[k] = s[48]; end
        if (cem) mdl_m[k] = mult_out;
        if (cecarryin) mdl_cin[k] = K_SELC[k] ? carryin : opmode[5];
      end
    end
  endtask

  task automatic check_inst(input int k, input string ph);
    logic [48:0] s;
    logic [47:0] gp, gpc, ep;
    logic [35:0] gm, em;
    logic        gco, gcof, eco;
    case (k)
      0:       begin gp = p_a; gpc = pc_a; gm = m_a; gco = co_a; gcof = cof_a; end
      1:       begin gp = p_b; gpc = pc_b; gm = m_b; gco = co_b; gcof = cof_b; end
      default: begin gp = p_c; gpc = pc_c; gm = m_c; gco = co_c; gcof = cof_c; end
    endcase
    s   = ref_sum(k);
    ep  = K_PREG[k]  ? mdl_p[k]  : s[47:0];
    eco = K_COREG[k] ? mdl_co[k] : s[48];
    em  = K_MREG[k]  ? mdl_m[k]  : mult_out;
    check_val($sformatf("%s_%0d_P", ph, k), gp, ep);
    check_val($sformatf("%s_%0d_PCOUT", ph, k), gpc, ep);
    check_val($sformatf("%s_%0d_CO", ph, k), gco, eco);
    check_val($sformatf("%s_%0d_COF", ph, k), gcof, eco);
    check_val($sformatf("%s_%0d_M", ph, k), gm, em);
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 3; k++) check_inst(k, ph);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    n_step++;
    $display("step %0d %s rst_n=%0b op=%02h mo=%0h P=%012h/%012h/%012h co=%0b%0b%0b",
             n_step, ph, rst_n, opmode, mult_out, p_a, p_b, p_c, co_a, co_b, co_c);
    check_all(ph);
  endtask

  task automatic apply(input logic [7:0] op, input logic [35:0] mo, input logic [47:0] cc,
                       input logic [47:0] cv, input logic [47:0] pc, input logic ci);
    opmode = op; mult_out = mo; conc_out = cc; c_in = cv; pcin = pc; carryin = ci;
    #1 check_all("comb");
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) t = 64'h0000_FFFF_FFFF_FFFF;
    return t[47:0];
  endfunction

  task automatic apply_random();
    logic [47:0] t;
    t = rnd48();
    apply($urandom_range(0, 255), t[35:0], rnd48(), rnd48(), rnd48(), $urandom_range(0, 1));
  endtask

  // Assert reset away from the clock edge and confirm registers clear with no edge.
  task automatic async_reset(input string ph);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val({ph, "_async_P"}, p_a, 48'd0);
    check_val({ph, "_async_CO"}, co_a, 1'b0);
    check_all(ph);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [47:0] hold_p;
  logic        hold_co;

  initial begin
    rst_n = 1'b0; cem = 1'b1; cecarryin = 1'b1; cep = 1'b1;
    model_reset();
    apply_random();
    repeat (3) begin
      step("rst_hold");
      check_val("rst_P", p_a, 48'd0);
      check_val("rst_M", m_a, 36'd0);
      check_val("rst_CO", co_a, 1'b0);
      apply_random();
    end
    @(negedge clk);
    rst_n = 1'b1;

    apply(8'h01, 36'd1000, 48'd0, 48'd0, 48'd0, 1'b0);
    step("mult"); step("mult");
    check_val("t2_P", p_a, 48'd1000);
    check_val("t2_CO", co_a, 1'b0);

    async_reset("acc");
    apply(8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0);
    step("acc");
    for (int i = 1; i <= 4; i++) begin
      step("acc");
      check_val($sformatf("t3_acc%0d", i), p_a, 48'd5 * i);
    end

    apply(8'hAD, 36'd3, 48'd0, 48'd10, 48'd0, 1'b0);
    step("sub"); step("sub");
    check_val("t4_P", p_a, 48'd6);
    check_val("t4_CO", co_a, 1'b0);
    apply(8'hAD, 36'd3, 48'd0, 48'd2, 48'd0, 1'b0);
    step("sub");
    check_val("t4_borrow_P", p_a, 48'hFFFF_FFFF_FFFE);
    check_val("t4_borrow_CO", co_a, 1'b1);

    apply(8'h0F, 36'd0, 48'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0);
    step("ovf"); step("ovf");
    check_val("t5_P", p_a, 48'd0);
    check_val("t5_CO", co_a, 1'b1);
    apply(8'h07, 36'd0, 48'd1, 48'hFFFF_FFFF_FFFF, 48'd7, 1'b0);
    step("pcin");
    check_val("t5_pcin_P", p_a, 48'd8);
    check_val("t5_pcin_PCOUT", pc_a, 48'd8);

    cep = 1'b0;
    hold_p = p_a; hold_co = co_a;
    repeat (4) begin
      apply_random();
      step("hold");
      check_val("t6_hold_P", p_a, hold_p);
      check_val("t6_hold_CO", co_a, hold_co);
    end
    cep = 1'b1;

    apply(8'h01, 36'd9, 48'd0, 48'd0, 48'd0, 1'b0);
    step("mbyp");
    check_val("t6_mbyp_P", p_b, 48'd9);
    apply(8'h0A, 36'd9, 48'd0, 48'd0, 48'd0, 1'b0);
    check_val("t6_pbyp_P", p_c, 48'd0);

    for (int i = 0; i < 400; i++) begin
      cem       = ($urandom_range(0, 3) != 0);
      cecarryin = ($urandom_range(0, 3) != 0);
      cep       = ($urandom_range(0, 3) != 0);
      // Bias toward accumulate opmodes so feedback paths see long runs.
      if ($urandom_range(0, 2) == 0) begin
        apply_random();
        opmode[3:2] = 2'd2;
        #1 check_all("comb");
      end else begin
        apply_random();
      end
      step("rand");
      if ($urandom_range(0, 39) == 0) async_reset("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
